// File: rtl/change_dispenser.sv
// Change dispenser: refunds an accepted balance as a paced train of 10- and 5-unit coins
// on the drop_money LED bar, with per-coin pulses and a completion pulse.
module change_dispenser #(
  parameter int BAL_W       = 8,
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [BAL_W-1:0] req_amount,
  input  logic             abort,
  output logic             req_ready,
  output logic             busy,
  output logic [9:0]       drop_money,
  output logic             coin10,
  output logic             coin5,
  output logic [BAL_W-1:0] remaining,
  output logic             done,
  output logic             err_odd
);

  localparam int MAX_DWELL = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BAL_W-1:0] FIVE    = BAL_W'(5);
  localparam logic [BAL_W-1:0] TEN     = BAL_W'(10);

  localparam logic [9:0] PAT_10 = 10'h3FF;
  localparam logic [9:0] PAT_5  = 10'h3E0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DROP = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [BAL_W-1:0] rem5;
  logic [BAL_W-1:0] amt5;
  logic [BAL_W-1:0] coin_base;
  logic [BAL_W-1:0] next_rem;
  logic             accept;
  logic             issue;
  logic             use_ten;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // One coin-issue path serves both the accept edge (from amt5) and the end of a gap (from remaining).
  always_comb begin
    rem5      = req_amount % FIVE;
    amt5      = req_amount - rem5;
    accept    = (state == S_IDLE) && req_valid;
    coin_base = (state == S_IDLE) ? amt5 : remaining;
    use_ten   = (coin_base >= TEN);
    next_rem  = use_ten ? (coin_base - TEN) : (coin_base - FIVE);
    issue     = (accept && (amt5 != '0)) ||
                ((state == S_GAP) && !abort && (cnt == '0) && (remaining >= FIVE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      drop_money <= '0;
      coin10     <= 1'b0;
      coin5      <= 1'b0;
      remaining  <= '0;
      done       <= 1'b0;
      err_odd    <= 1'b0;
    end else begin
      coin10  <= 1'b0;
      coin5   <= 1'b0;
      done    <= 1'b0;
      err_odd <= 1'b0;
      if (accept) err_odd <= (rem5 != '0);

      if (issue) begin
        state      <= S_DROP;
        cnt        <= HOLD_LD;
        drop_money <= use_ten ? PAT_10 : PAT_5;
        coin10     <= use_ten;
        coin5      <= !use_ten;
        remaining  <= next_rem;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              remaining <= '0;
              state     <= S_DONE;
              cnt       <= '0;
              done      <= 1'b1;
            end
          end
          S_DROP: begin
            if (abort) begin
              drop_money <= '0;
              state      <= S_DONE;
              cnt        <= '0;
              done       <= 1'b1;
            end else if (cnt == '0) begin
              drop_money <= '0;
              state      <= S_GAP;
              cnt        <= GAP_LD;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_GAP: begin
            // Reaching here with cnt==0 means fewer than 5 units are left.
            if (abort || (cnt == '0)) begin
              drop_money <= '0;
              state      <= S_DONE;
              cnt        <= '0;
              done       <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
